la_readback_engine: RTL and testbench
=====================================

Name: la_readback_engine

Overview:
- Reads a captured logic-analyzer sample region back out of DDR3 through the MIG user (app_*) read interface, the reverse of the capture write path.
- Issues aligned 256-bit read commands over a circular per-channel region.
- Collects returning app_rd_data into a credit-protected FIFO, since MIG read data cannot be back-pressured.
- Presents the data as a valid/ready stream to the host readout logic, all in clk_ram.

Parameters:
- FIFO_DEPTH, 32: readback FIFO entries (256-bit each); power of two, minimum 4.
- ADDR_STEP, 4: app_addr increment per 256-bit read (64-bit word units).
- REGION_LOG2, 23: log2 of channel region size in 64-bit words (64 MB); address wraps within the region.
- COUNT_WIDTH, 21: width of the burst count.

Ports:
- clk_ram  in  1  MIG UI clock; all logic in this domain.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; latches base_addr, start_offset, burst_count; ignored unless idle.
- abort  in  1  one-cycle pulse; cancels the active transfer.
- base_addr  in  29  region base; low REGION_LOG2 bits ignored.
- start_offset  in  23  first word offset within the region; must be a multiple of ADDR_STEP.
- burst_count  in  COUNT_WIDTH  number of 256-bit reads; 0 means done immediately.
- busy  out  1  high from the start-accept cycle until return to IDLE.
- done  out  1  one-cycle pulse when all data has been handed off.
- aborted  out  1  one-cycle pulse when abort cleanup completes.
- app_addr  out  29  MIG command address.
- app_cmd  out  3  always 3'b001 (read).
- app_en  out  1  command valid.
- app_rdy  in  1  MIG command accept.
- app_rd_data  in  256  MIG read data.
- app_rd_data_valid  in  1  read data strobe.
- app_rd_data_end  in  1  end of burst; unused, tied off internally.
- out_valid  out  1  stream valid.
- out_data  out  256  stream data.
- out_ready  in  1  stream accept.

Behaviour:
- Reset values: busy=0, done=0, aborted=0, app_en=0, app_addr=0, out_valid=0; FIFO empty; credits=FIFO_DEPTH; state IDLE.
- IDLE -> ISSUE on start (burst_count>0). On start with burst_count=0: pulse done on the next cycle and stay in IDLE.
- ISSUE: app_en=1 when credits>0.
  - A command is accepted when app_en && app_rdy. Acceptance decrements credits and the remaining count, and advances the offset by ADDR_STEP modulo 2^REGION_LOG2.
  - app_addr = {base_addr[28:REGION_LOG2], offset}.
  - app_addr and app_en are registered and held stable until accepted.
  - After the last command is accepted, go to DRAIN.
- Credits = FIFO_DEPTH - (outstanding reads + FIFO occupancy). Increment on an out_valid&&out_ready pop; decrement on command accept. Both in one cycle leaves credits unchanged.
- app_rd_data_valid writes the FIFO unconditionally. The credit scheme guarantees no overflow.
- DRAIN -> IDLE with a done pulse once outstanding==0, the FIFO is empty, and the final pop has occurred.
- Output: out_data/out_valid come from the FIFO head (first-word fall-through). Latency from rd_data_valid to out_valid is 1 cycle.
- Abort (ISSUE or DRAIN) -> ABORT state:
  - app_en drops the next cycle unless a command is in the app_en&&!app_rdy phase; such a command is completed first, since MIG commands cannot be retracted.
  - FIFO flushed, out_valid=0; returning data is discarded.
  - When outstanding==0: go to IDLE and pulse aborted.
- Simultaneous start and abort while idle: start wins, abort is ignored.
- rst_n mid-transfer: immediate return to reset values. The system must reset the MIG as well.

Optional Feature:
- Macro LA_READBACK_PERF_EN.
- When defined, adds two output ports:
  - stall_cycles[31:0]: cycles with app_en && !app_rdy.
  - backpressure_cycles[31:0]: cycles with ISSUE && credits==0.
  - Both cleared on start, saturate at all-ones, hold after done.
- When undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- Package la_readback_pkg: MIG command encodings (CMD_READ=3'b001, CMD_WRITE=3'b000), state enum (IDLE, ISSUE, DRAIN, ABORT), region constants shared with the capture arbiter.
- Sub-module la_readback_fifo: synchronous FWFT FIFO, 256 bits wide, FIFO_DEPTH deep, with flush input and occupancy output.

Test Plan:
- Basic read, always-ready MIG: start, base=0x0800_0000, offset 0, count 8 -> 8 commands at app_addr 0x0800_0000..0x0800_001C step 4. out_data returns the model's pattern in order. done pulses once.
- Wrap-around: offset 0x7FFFF8, count 4 -> addresses region+0x7FFFF8, +0x7FFFFC, +0x000000, +0x000004; upper bits unchanged.
- Backpressure: FIFO_DEPTH=32, out_ready=0, count 100 -> exactly 32 commands issued, then app_en=0. Releasing out_ready resumes; all 100 words delivered with no loss.
- app_rdy random 50% and 20-cycle read latency -> no dropped or duplicated words; app_addr held stable while !app_rdy.
- Abort after 10 of 40 issued, with 6 in flight -> no further commands. The 6 returns are discarded, out_valid stays 0, then aborted pulses and done does not.
- count=0 start -> done the next cycle, no app_en. rst_n asserted mid-DRAIN -> all outputs return to reset values within the same cycle.

Source files
------------

// File: rtl/la_readback_pkg.sv
// Shared definitions for the logic-analyzer DDR3 readback path: MIG command
// encodings, readback FSM states and region geometry constants that the
// capture arbiter uses as well.
package la_readback_pkg;

   localparam logic [2:0] CMD_READ  = 3'b001;
   localparam logic [2:0] CMD_WRITE = 3'b000;

   localparam int APP_ADDR_W          = 29;
   localparam int APP_DATA_W          = 256;
   localparam int REGION_LOG2_DEFAULT = 23;
   localparam int OFFSET_PORT_W       = 23;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      DRAIN,
      ABORT
   } rb_state_t;

   // Increment that sticks at all-ones instead of wrapping.
   function automatic logic [31:0] sat_inc32(input logic [31:0] v);
      return (&v) ? v : v + 32'd1;
   endfunction

endpackage

// File: rtl/la_readback_fifo.sv
// First-word-fall-through FIFO holding returned MIG read data. The head entry
// is visible on rd_data whenever empty is low; flush discards all contents.
module la_readback_fifo
   import la_readback_pkg::*;
#(
   parameter int DEPTH = 32,
   parameter int WIDTH = APP_DATA_W,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic             clk_ram,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_data,
   output logic             empty,
   output logic [AW:0]      occupancy
);

   localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr_reg;
   logic [AW-1:0]    rd_ptr_reg;
   logic [AW:0]      count_reg;
   logic             do_wr;
   logic             do_rd;

   assign do_wr = wr_en && !flush && (count_reg != FULL_COUNT);
   assign do_rd = rd_en && !flush && (count_reg != '0);

   // Storage array; written at the tail, no reset needed for the data itself.
   always_ff @(posedge clk_ram) begin
      if (do_wr) mem[wr_ptr_reg] <= wr_data;
   end

   // Pointer and occupancy bookkeeping; flush empties the FIFO in one cycle.
   always_ff @(posedge clk_ram or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else if (flush) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (do_wr) wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (do_rd) rd_ptr_reg <= rd_ptr_reg + 1'b1;
         count_reg <= count_reg + (AW + 1)'(do_wr) - (AW + 1)'(do_rd);
      end
   end

   assign rd_data   = mem[rd_ptr_reg];
   assign empty     = (count_reg == '0);
   assign occupancy = count_reg;

endmodule

// File: rtl/la_readback_engine.sv
// Reads a captured sample region back out of DDR3 over the MIG app_* read
// interface. Read commands are only issued while FIFO credits remain, so the
// non-stallable MIG read data can never overflow the readback FIFO.
// Optional macro LA_READBACK_PERF_EN adds stall/backpressure cycle counters.
module la_readback_engine
   import la_readback_pkg::*;
#(
   parameter int FIFO_DEPTH  = 32,
   parameter int ADDR_STEP   = 4,
   parameter int REGION_LOG2 = REGION_LOG2_DEFAULT,
   parameter int COUNT_WIDTH = 21
) (
   input  logic                     clk_ram,
   input  logic                     rst_n,
   input  logic                     start,
   input  logic                     abort,
   input  logic [APP_ADDR_W-1:0]    base_addr,
   input  logic [OFFSET_PORT_W-1:0] start_offset,
   input  logic [COUNT_WIDTH-1:0]   burst_count,
   output logic                     busy,
   output logic                     done,
   output logic                     aborted,
   output logic [APP_ADDR_W-1:0]    app_addr,
   output logic [2:0]               app_cmd,
   output logic                     app_en,
   input  logic                     app_rdy,
   input  logic [APP_DATA_W-1:0]    app_rd_data,
   input  logic                     app_rd_data_valid,
   input  logic                     app_rd_data_end,
   output logic                     out_valid,
   output logic [APP_DATA_W-1:0]    out_data,
   input  logic                     out_ready
`ifdef LA_READBACK_PERF_EN
   ,
   output logic [31:0]              stall_cycles,
   output logic [31:0]              backpressure_cycles
`endif
);

   localparam int OW = REGION_LOG2;
   localparam int HW = APP_ADDR_W - REGION_LOG2;
   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
   localparam logic [OW-1:0] STEP_C  = OW'(ADDR_STEP);

   rb_state_t               state_reg, state_next;
   logic [HW-1:0]           base_hi_reg, base_hi_next;
   logic [OW-1:0]           offset_reg, offset_next;
   logic [COUNT_WIDTH-1:0]  remaining_reg, remaining_next;
   logic [CW-1:0]           outstanding_reg, outstanding_next;
   logic                    app_en_reg, app_en_next;
   logic [APP_ADDR_W-1:0]   app_addr_reg, app_addr_next;
   logic                    done_reg, done_next;
   logic                    aborted_reg, aborted_next;

   logic [CW-1:0]           occupancy;
   logic [CW-1:0]           credits;
   logic [CW-1:0]           credits_after;
   logic                    fifo_empty;
   logic                    fifo_flush;
   logic                    accept;
   logic                    pop;
   logic                    start_accept;
   logic                    unused_inputs;

   assign unused_inputs = &{1'b0, app_rd_data_end, base_addr[REGION_LOG2-1:0]};

   assign accept       = app_en_reg && app_rdy;
   assign start_accept = (state_reg == IDLE) && start;
   assign fifo_flush   = (state_reg == ABORT);
   assign out_valid    = !fifo_empty && (state_reg != ABORT);
   assign pop          = out_valid && out_ready;

   // Free FIFO slots not yet promised to an outstanding read.
   assign credits       = DEPTH_C - outstanding_reg - occupancy;
   assign credits_after = credits - CW'(accept) + CW'(pop);

   la_readback_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (APP_DATA_W)
   ) u_fifo (
      .clk_ram   (clk_ram),
      .rst_n     (rst_n),
      .flush     (fifo_flush),
      .wr_en     (app_rd_data_valid),
      .wr_data   (app_rd_data),
      .rd_en     (pop),
      .rd_data   (out_data),
      .empty     (fifo_empty),
      .occupancy (occupancy)
   );

   // State register and command/transfer bookkeeping.
   always_ff @(posedge clk_ram or negedge rst_n) begin
      if (!rst_n) begin
         state_reg       <= IDLE;
         base_hi_reg     <= '0;
         offset_reg      <= '0;
         remaining_reg   <= '0;
         outstanding_reg <= '0;
         app_en_reg      <= 1'b0;
         app_addr_reg    <= '0;
         done_reg        <= 1'b0;
         aborted_reg     <= 1'b0;
      end else begin
         state_reg       <= state_next;
         base_hi_reg     <= base_hi_next;
         offset_reg      <= offset_next;
         remaining_reg   <= remaining_next;
         outstanding_reg <= outstanding_next;
         app_en_reg      <= app_en_next;
         app_addr_reg    <= app_addr_next;
         done_reg        <= done_next;
         aborted_reg     <= aborted_next;
      end
   end

   // Next-state, address sequencing and registered command generation.
   always_comb begin
      state_next       = state_reg;
      base_hi_next     = base_hi_reg;
      offset_next      = offset_reg;
      remaining_next   = remaining_reg;
      outstanding_next = outstanding_reg + CW'(accept) - CW'(app_rd_data_valid);
      done_next        = 1'b0;
      aborted_next     = 1'b0;
      app_en_next      = 1'b0;

      // Offset wraps naturally inside the region through its width.
      if (accept) begin
         offset_next    = offset_reg + STEP_C;
         remaining_next = remaining_reg - COUNT_WIDTH'(1);
      end

      case (state_reg)
         IDLE: begin
            if (start) begin
               base_hi_next   = base_addr[APP_ADDR_W-1:REGION_LOG2];
               offset_next    = start_offset[OW-1:0];
               remaining_next = burst_count;
               if (burst_count == '0) done_next  = 1'b1;
               else                   state_next = ISSUE;
            end
         end
         ISSUE: begin
            if (abort)                                               state_next = ABORT;
            else if (accept && remaining_reg == COUNT_WIDTH'(1))     state_next = DRAIN;
         end
         DRAIN: begin
            if (abort) begin
               state_next = ABORT;
            end else if (outstanding_reg == '0 && fifo_empty) begin
               state_next = IDLE;
               done_next  = 1'b1;
            end
         end
         ABORT: begin
            if (outstanding_reg == '0 && !app_en_reg) begin
               state_next   = IDLE;
               aborted_next = 1'b1;
            end
         end
         default: state_next = IDLE;
      endcase

      // A presented command is never retracted, even across an abort.
      if (app_en_reg && !app_rdy)
         app_en_next = 1'b1;
      else if (state_next == ISSUE && remaining_next != '0 && credits_after != '0)
         app_en_next = 1'b1;

      app_addr_next = {base_hi_next, offset_next};
   end

   assign busy     = (state_reg != IDLE);
   assign done     = done_reg;
   assign aborted  = aborted_reg;
   assign app_en   = app_en_reg;
   assign app_addr = app_addr_reg;
   assign app_cmd  = CMD_READ;

`ifdef LA_READBACK_PERF_EN
   logic [1:0] perf_event;
   assign perf_event[0] = app_en_reg && !app_rdy;
   assign perf_event[1] = (state_reg == ISSUE) && (credits == '0);

   for (genvar gi = 0; gi < 2; gi++) begin : g_perf
      logic [31:0] cnt_reg;
      // Saturating event counter, restarted by each accepted start.
      always_ff @(posedge clk_ram or negedge rst_n) begin
         if (!rst_n)              cnt_reg <= '0;
         else if (start_accept)   cnt_reg <= '0;
         else if (perf_event[gi]) cnt_reg <= sat_inc32(cnt_reg);
      end
   end

   assign stall_cycles        = g_perf[0].cnt_reg;
   assign backpressure_cycles = g_perf[1].cnt_reg;
`endif

endmodule

// File: tb/tb_la_readback_engine.sv
// Directed bench for la_readback_engine with a small MIG read model
// (configurable app_rdy duty and read latency) and an in-order data scoreboard.
module tb_la_readback_engine;

   logic          clk_ram;
   logic          rst_n;
   logic          start;
   logic          abort;
   logic [28:0]   base_addr;
   logic [22:0]   start_offset;
   logic [20:0]   burst_count;
   logic          busy;
   logic          done;
   logic          aborted;
   logic [28:0]   app_addr;
   logic [2:0]    app_cmd;
   logic          app_en;
   logic          app_rdy;
   logic [255:0]  app_rd_data;
   logic          app_rd_data_valid;
   logic          app_rd_data_end;
   logic          out_valid;
   logic [255:0]  out_data;
   logic          out_ready;
`ifdef LA_READBACK_PERF_EN
   logic [31:0]   stall_cycles;
   logic [31:0]   backpressure_cycles;
`endif

   la_readback_engine dut (
      .clk_ram           (clk_ram),
      .rst_n             (rst_n),
      .start             (start),
      .abort             (abort),
      .base_addr         (base_addr),
      .start_offset      (start_offset),
      .burst_count       (burst_count),
      .busy              (busy),
      .done              (done),
      .aborted           (aborted),
      .app_addr          (app_addr),
      .app_cmd           (app_cmd),
      .app_en            (app_en),
      .app_rdy           (app_rdy),
      .app_rd_data       (app_rd_data),
      .app_rd_data_valid (app_rd_data_valid),
      .app_rd_data_end   (app_rd_data_end),
      .out_valid         (out_valid),
      .out_data          (out_data),
      .out_ready         (out_ready)
`ifdef LA_READBACK_PERF_EN
      ,
      .stall_cycles        (stall_cycles),
      .backpressure_cycles (backpressure_cycles)
`endif
   );

   initial clk_ram = 1'b0;
   always #5 clk_ram = ~clk_ram;

   typedef struct {
      int          due;
      logic [28:0] addr;
   } rd_t;

   rd_t         mig_q[$];
   logic [28:0] cmd_addr_q[$];
   logic [28:0] exp_data_q[$];

   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          n_cmds, n_pops, n_done, n_aborted;
   int          bp_cmds;
   bit          bp_en;
   bit          abort_phase;
   bit          prev_wait;
   bit          prev_rdv;
   logic [28:0] prev_addr;

   task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [255:0] pat(input logic [28:0] a);
      logic [31:0] w;
      w = 32'hC0DE_0000 ^ {3'b000, a};
      return {8{w}};
   endfunction

   // One clock of MIG model + stream sink, evaluated at the falling edge.
   task automatic tick(input int rdy_pct, input int lat, input bit oready, input bit do_abort);
      rd_t r;
      @(negedge clk_ram);
      cyc++;
      if (done)    n_done++;
      if (aborted) n_aborted++;
      if (prev_wait) begin
         check("hold_en", app_en, 1);
         check("hold_addr", app_addr, prev_addr);
      end
      if (prev_rdv && !abort_phase) check("rd_lat", out_valid, 1);
      if (abort_phase)              check("abort_ov", out_valid, 0);

      start     = 1'b0;
      abort     = do_abort;
      out_ready = oready;
      app_rdy   = (int'($urandom_range(99)) < rdy_pct);
      if (mig_q.size() != 0 && mig_q[0].due <= cyc) begin
         r = mig_q.pop_front();
         app_rd_data_valid = 1'b1;
         app_rd_data       = pat(r.addr);
      end else begin
         app_rd_data_valid = 1'b0;
         app_rd_data       = '0;
      end
      prev_rdv = app_rd_data_valid && !do_abort;

      if (app_en && app_rdy) begin
         n_cmds++;
         cmd_addr_q.push_back(app_addr);
         r.due  = cyc + lat;
         r.addr = app_addr;
         mig_q.push_back(r);
         if (!abort_phase && !do_abort) exp_data_q.push_back(app_addr);
      end
      prev_wait = app_en && !app_rdy;
      prev_addr = app_addr;

      if (out_valid && out_ready) begin
         n_pops++;
         if (exp_data_q.size() == 0) check("pop_underflow", n_pops, 0);
         else                        check("data", out_data, pat(exp_data_q.pop_front()));
      end
      if (do_abort) abort_phase = 1'b1;
   endtask

   task automatic start_xfer(input logic [28:0] base, input logic [22:0] off, input int cnt);
      n_cmds = 0; n_pops = 0; n_done = 0; n_aborted = 0;
      bp_cmds = -1; bp_en = 1'b1; abort_phase = 1'b0;
      cmd_addr_q.delete();
      exp_data_q.delete();
      @(negedge clk_ram);
      cyc++;
      start             = 1'b1;
      abort             = 1'b0;
      base_addr         = base;
      start_offset      = off;
      burst_count       = 21'(cnt);
      app_rdy           = 1'b0;
      app_rd_data_valid = 1'b0;
      out_ready         = 1'b0;
      prev_wait         = 1'b0;
      prev_rdv          = 1'b0;
   endtask

   task automatic run_loop(input int rdy_pct, input int lat, input int hold_ready,
                           input int abort_at, input int budget);
      int t, tail;
      bit sent, ab;
      t = 0; tail = -1; sent = 1'b0;
      while (t < budget && tail != 0) begin
         if (t == hold_ready) begin
            bp_cmds = n_cmds;
            bp_en   = app_en;
         end
         ab = (abort_at >= 0) && !sent && (n_cmds >= abort_at);
         if (ab) sent = 1'b1;
         tick(rdy_pct, lat, t >= hold_ready, ab);
         if (tail > 0)                                     tail--;
         else if (tail < 0 && (n_done != 0 || n_aborted != 0)) tail = 3;
         t++;
      end
      check("finished", tail == 0, 1);
      $display("xfer cmds=%0d pops=%0d done=%0d aborted=%0d cycle=%0d",
               n_cmds, n_pops, n_done, n_aborted, cyc);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; start = 1'b0; abort = 1'b0;
      base_addr = '0; start_offset = '0; burst_count = '0;
      app_rdy = 1'b0; app_rd_data = '0; app_rd_data_valid = 1'b0;
      app_rd_data_end = 1'b0; out_ready = 1'b0;
      prev_wait = 1'b0; prev_rdv = 1'b0; prev_addr = '0;

      // Reset state
      repeat (3) @(negedge clk_ram);
      rst_n = 1'b1;
      @(negedge clk_ram);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_aborted", aborted, 0);
      check("rst_app_en", app_en, 0);
      check("rst_app_addr", app_addr, 0);
      check("rst_out_valid", out_valid, 0);
      check("app_cmd", app_cmd, 3'b001);

      // Basic read, MIG always ready
      start_xfer(29'h0800_0000, 23'h0, 8);
      run_loop(100, 5, 0, -1, 300);
      check("basic_cmds", n_cmds, 8);
      for (int k = 0; k < 8; k++)
         check("basic_addr", cmd_addr_q[k], 29'h0800_0000 + 29'(4 * k));
      check("basic_pops", n_pops, 8);
      check("basic_done", n_done, 1);
      check("basic_aborted", n_aborted, 0);
      check("basic_idle", busy, 0);

      // Wrap inside the region, upper address bits preserved
      start_xfer(29'h0800_0000, 23'h7F_FFF8, 4);
      run_loop(100, 3, 0, -1, 300);
      check("wrap_cmds", n_cmds, 4);
      check("wrap_addr0", cmd_addr_q[0], 29'h087F_FFF8);
      check("wrap_addr1", cmd_addr_q[1], 29'h087F_FFFC);
      check("wrap_addr2", cmd_addr_q[2], 29'h0800_0000);
      check("wrap_addr3", cmd_addr_q[3], 29'h0800_0004);
      check("wrap_pops", n_pops, 4);
      check("wrap_done", n_done, 1);

      // Credit backpressure: stream stalled for 200 cycles
      start_xfer(29'h1000_0000, 23'h100, 100);
      run_loop(100, 8, 200, -1, 3000);
      check("bp_cmds_at_stall", bp_cmds, 32);
      check("bp_app_en_at_stall", bp_en, 0);
      check("bp_cmds", n_cmds, 100);
      check("bp_pops", n_pops, 100);
      check("bp_done", n_done, 1);

      // 50% app_rdy with long read latency
      start_xfer(29'h0A00_0000, 23'h40, 30);
      run_loop(50, 20, 0, -1, 3000);
      check("rnd_cmds", n_cmds, 30);
      for (int k = 0; k < 30; k++)
         check("rnd_addr", cmd_addr_q[k], 29'h0A00_0040 + 29'(4 * k));
      check("rnd_pops", n_pops, 30);
      check("rnd_done", n_done, 1);

      // Abort after 10 commands; the command in the abort cycle still goes out
      start_xfer(29'h0400_0000, 23'h0, 40);
      run_loop(100, 6, 0, 10, 500);
      check("abort_cmds", n_cmds, 11);
      check("abort_pulse", n_aborted, 1);
      check("abort_no_done", n_done, 0);
      check("abort_idle", busy, 0);
      check("abort_mig_empty", mig_q.size(), 0);

      // Zero-length transfer
      start_xfer(29'h0200_0000, 23'h0, 0);
      @(negedge clk_ram);
      start = 1'b0;
      check("zero_done", done, 1);
      check("zero_app_en", app_en, 0);
      check("zero_busy", busy, 0);
      @(negedge clk_ram);
      check("zero_done_once", done, 0);
      $display("xfer zero-length done checked cycle=%0d", cyc);

      // Reset in the middle of DRAIN
      start_xfer(29'h0C00_0000, 23'h0, 4);
      for (int k = 0; k < 6; k++) tick(100, 10, 1'b0, 1'b0);
      check("drain_busy", busy, 1);
      check("drain_cmds", n_cmds, 4);
      rst_n = 1'b0;
      #1;
      check("mid_rst_busy", busy, 0);
      check("mid_rst_app_en", app_en, 0);
      check("mid_rst_app_addr", app_addr, 0);
      check("mid_rst_out_valid", out_valid, 0);
      check("mid_rst_done", done, 0);
      mig_q.delete();
      app_rd_data_valid = 1'b0;
      prev_wait = 1'b0;
      prev_rdv  = 1'b0;
      @(negedge clk_ram);
      rst_n = 1'b1;
      @(negedge clk_ram);
      check("post_rst_busy", busy, 0);
      $display("xfer reset-in-drain checked cycle=%0d", cyc);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
